mskaes_interleaved_round_ctrl: RTL and testbench

- Sequencing and output-buffer block for the masked round-based AES datapath.
- Generalises single-block round control: time-multiplexes up to S = LATENCY+1 independent blocks ("slots") through the pipelined round logic.
- Round count NR is a parameter, so longer schedules (NR=12/14) reuse the same control.
- Buffers shared ciphertext in a tagged output FIFO with valid/ready backpressure; admission is credit-controlled, so the FIFO never overflows.

---
 rtl/mskaes_interleaved_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mskaes_interleaved_round_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_interleaved_round_ctrl.sv
// Round sequencer and tagged output buffer for the masked round-based AES core.
// Up to LATENCY+1 independent blocks share the pipelined round logic, one slot
// per cycle in round-robin order. Finished blocks are queued with their tag in
// a small FWFT FIFO. Admission is credit-based, so the FIFO can never overflow.
module mskaes_interleaved_round_ctrl #(
   parameter int d         = 4,
   parameter int LATENCY   = 2,
   parameter int NR        = 10,
   parameter int OUT_DEPTH = 2,
   parameter int TAGW      = 4
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [TAGW-1:0]                    in_tag,
   output logic                               dp_fetch,
   output logic                               dp_feedback,
   output logic                               dp_final,
   output logic                               dp_clean,
   output logic [7:0]                         dp_rcon,
   output logic [$clog2(LATENCY+1)-1:0]       dp_slot,
   input  logic [128*d-1:0]                   dp_sh_state,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [TAGW-1:0]                    out_tag,
   output logic [128*d-1:0]                   out_sh_ciphertext,
   output logic [$clog2(LATENCY+2)-1:0]       inflight
);

   localparam int S  = LATENCY + 1;
   localparam int SW = $clog2(S);
   localparam int IW = $clog2(S + 1);
   localparam int DW = 128 * d;
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int RW = 4;

   // Slot pointer and per-slot context
   logic [SW-1:0]        sp;
   logic [S-1:0]         busy;
   logic [RW-1:0]        rnd  [S];
   logic [7:0]           rcon [S];
   logic [TAGW-1:0]      tag  [S];

   // Output FIFO storage: {tag, shared ciphertext}
   logic [TAGW+DW-1:0]   mem [OUT_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        fifo_count;

   logic                 cur_busy;
   logic [RW-1:0]        cur_r;
   logic [7:0]           next_rcon;
   logic                 has_credit;
   logic                 accept;
   logic                 step;
   logic                 capture;
   logic                 push;
   logic                 pop;
   logic [IW-1:0]        inflight_cnt;

   // GF(2^8) doubling used to advance the round constant
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Number of slots currently carrying a block
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < S; i++) begin
         inflight_cnt = inflight_cnt + IW'(busy[i]);
      end
   end

   // Slot decode, admission credit and datapath strobes; all forced low in reset
   always_comb begin
      cur_busy   = busy[sp];
      cur_r      = rnd[sp];
      next_rcon  = xtime(rcon[sp]);
      has_credit = (int'(fifo_count) + int'(inflight_cnt)) < OUT_DEPTH;
      in_ready   = nrst & ~cur_busy & has_credit;
      accept     = in_valid & in_ready;
      step       = nrst & cur_busy & (cur_r < RW'(NR));
      capture    = nrst & cur_busy & (cur_r == RW'(NR));
      push       = capture;
      pop        = out_valid & out_ready;
      dp_fetch    = accept;
      dp_feedback = step;
      dp_final    = step & (cur_r == RW'(NR - 1));
      dp_clean    = capture;
      dp_rcon     = 8'h00;
      if (accept) begin
         dp_rcon = 8'h01;
      end else if (step) begin
         dp_rcon = next_rcon;
      end
      dp_slot  = sp;
      inflight = inflight_cnt;
   end

   // FIFO head presentation (first-word-fall-through)
   always_comb begin
      out_valid         = (fifo_count != '0);
      out_tag           = mem[rd_ptr][TAGW+DW-1:DW];
      out_sh_ciphertext = mem[rd_ptr][DW-1:0];
   end

   // Control state: slot pointer, busy flags and FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sp         <= '0;
         busy       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         sp <= (sp == SW'(S - 1)) ? '0 : sp + 1'b1;
         if (accept) begin
            busy[sp] <= 1'b1;
         end else if (capture) begin
            busy[sp] <= 1'b0;
         end
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Slot payload and FIFO data; no reset needed since busy/count qualify them
   always_ff @(posedge clk) begin
      if (accept) begin
         rnd[sp]  <= RW'(1);
         rcon[sp] <= 8'h01;
         tag[sp]  <= in_tag;
      end else if (step) begin
         rnd[sp]  <= cur_r + 1'b1;
         rcon[sp] <= next_rcon;
      end
      if (push) begin
         mem[wr_ptr] <= {tag[sp], dp_sh_state};
      end
   end

   // Credit invariant: queued plus in-flight blocks never exceed FIFO capacity
   always_ff @(posedge clk) begin
      if (nrst) begin
         assert ((int'(fifo_count) + int'(inflight_cnt)) <= OUT_DEPTH);
         assert (!(push && !pop && (int'(fifo_count) == OUT_DEPTH)));
      end
   end

endmodule

// File: tb/tb_mskaes_interleaved_round_ctrl.sv
// Directed bench for mskaes_interleaved_round_ctrl: default instance (NR=10,
// OUT_DEPTH=2) plus a long-schedule instance (NR=14, OUT_DEPTH=3).
module tb_mskaes_interleaved_round_ctrl;

   logic         clk;
   logic         nrst;

   logic         in_valid, in_ready, dp_fetch, dp_feedback, dp_final, dp_clean;
   logic [3:0]   in_tag, out_tag;
   logic [7:0]   dp_rcon;
   logic [1:0]   dp_slot, inflight;
   logic [511:0] dp_sh_state, out_sh_ciphertext;
   logic         out_valid, out_ready;

   logic         l_in_valid, l_in_ready, l_dp_fetch, l_dp_feedback, l_dp_final, l_dp_clean;
   logic [3:0]   l_in_tag, l_out_tag;
   logic [7:0]   l_dp_rcon;
   logic [1:0]   l_dp_slot, l_inflight;
   logic [511:0] l_dp_sh_state, l_out_sh_ciphertext;
   logic         l_out_valid, l_out_ready;

   int           n_chk;
   int           n_fail;
   int           cyc;
   int           acc;
   logic [511:0] exp_data;
   logic [7:0]   rc_tbl [13];

   mskaes_interleaved_round_ctrl u_dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
      .dp_fetch(dp_fetch), .dp_feedback(dp_feedback), .dp_final(dp_final),
      .dp_clean(dp_clean), .dp_rcon(dp_rcon), .dp_slot(dp_slot),
      .dp_sh_state(dp_sh_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_sh_ciphertext(out_sh_ciphertext), .inflight(inflight)
   );

   mskaes_interleaved_round_ctrl #(.NR(14), .OUT_DEPTH(3)) u_long (
      .clk(clk), .nrst(nrst),
      .in_valid(l_in_valid), .in_ready(l_in_ready), .in_tag(l_in_tag),
      .dp_fetch(l_dp_fetch), .dp_feedback(l_dp_feedback), .dp_final(l_dp_final),
      .dp_clean(l_dp_clean), .dp_rcon(l_dp_rcon), .dp_slot(l_dp_slot),
      .dp_sh_state(l_dp_sh_state),
      .out_valid(l_out_valid), .out_ready(l_out_ready), .out_tag(l_out_tag),
      .out_sh_ciphertext(l_out_sh_ciphertext), .inflight(l_inflight)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic drive_sh();
      dp_sh_state   = {16{32'hA5000000 | cyc}};
      l_dp_sh_state = {16{32'h5A000000 | cyc}};
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      cyc++;
      drive_sh();
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      in_valid = 1'b0; l_in_valid = 1'b0;
      out_ready = 1'b0; l_out_ready = 1'b0;
      in_tag = '0; l_in_tag = '0;
      next();
      next();
      nrst = 1'b1;
      cyc = 0;
      drive_sh();
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; acc = 0;
      rc_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36,
                 8'h6c, 8'hd8, 8'hab, 8'h4d};
      nrst = 1'b0;
      in_valid = 1'b0; l_in_valid = 1'b0;
      out_ready = 1'b0; l_out_ready = 1'b0;
      in_tag = '0; l_in_tag = '0;
      drive_sh();

      // Reset state
      next();
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_inflight", inflight, 2'd0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_slot", dp_slot, 2'd0);

      // Single block, tag 5, held at the FIFO head with out_ready low
      do_reset();
      in_valid = 1'b1; in_tag = 4'd5; #1;
      chk("sb_in_ready", in_ready, 1'b1);
      chk("sb_fetch", dp_fetch, 1'b1);
      chk("sb_fetch_rcon", dp_rcon, 8'h01);
      chk("sb_fetch_slot", dp_slot, 2'd0);
      exp_data = '0;
      for (int c = 1; c <= 32; c++) begin
         logic fb;
         next();
         in_valid = 1'b0; #1;
         fb = (c % 3 == 0) && (c >= 3) && (c <= 27);
         chk("sb_feedback", dp_feedback, fb);
         chk("sb_rcon", dp_rcon, fb ? rc_tbl[c/3-1] : 8'h00);
         chk("sb_final", dp_final, c == 27);
         chk("sb_clean", dp_clean, c == 30);
         chk("sb_fetch_idle", dp_fetch, 1'b0);
         chk("sb_out_valid", out_valid, c >= 31);
         chk("sb_inflight", inflight, (c <= 30) ? 2'd1 : 2'd0);
         if (c == 30) exp_data = dp_sh_state;
         if (c >= 31) begin
            chk("sb_out_tag", out_tag, 4'd5);
            chk("sb_out_data", out_sh_ciphertext, exp_data);
         end
      end
      out_ready = 1'b1;
      next();
      out_ready = 1'b0; #1;
      chk("sb_popped", out_valid, 1'b0);

      // Backpressure: out_ready low, in_valid held high
      do_reset();
      acc = 0;
      for (int c = 0; c <= 45; c++) begin
         if (c > 0) next();
         in_valid = 1'b1; in_tag = 4'(c); out_ready = (c == 40); #1;
         if (in_ready) acc++;
         if (c == 2)  chk("bp_refuse", in_ready, 1'b0);
         if (c == 39) begin
            chk("bp_two_accepted", acc, 2);
            chk("bp_head_valid", out_valid, 1'b1);
            chk("bp_head_tag", out_tag, 4'd0);
            chk("bp_blocked", in_ready, 1'b0);
         end
         if (c == 41) begin
            chk("bp_credit_back", in_ready, 1'b1);
            chk("bp_next_head", out_tag, 4'd1);
         end
         if (c == 42) chk("bp_refuse_again", in_ready, 1'b0);
      end
      chk("bp_total_accepted", acc, 3);
      in_valid = 1'b0;

      // Capture coinciding with a pop keeps the count at one
      do_reset();
      for (int c = 0; c <= 33; c++) begin
         if (c > 0) next();
         in_valid = (c < 2); in_tag = (c == 0) ? 4'hA : 4'hB;
         out_ready = (c == 31) || (c == 32); #1;
         if (c == 2) begin
            chk("pp_inflight", inflight, 2'd2);
            chk("pp_no_credit", in_ready, 1'b0);
         end
         if (c == 31) begin
            chk("pp_head_a", out_tag, 4'hA);
            chk("pp_capture_b", dp_clean, 1'b1);
         end
         if (c == 32) begin
            chk("pp_valid", out_valid, 1'b1);
            chk("pp_head_b", out_tag, 4'hB);
            chk("pp_one_credit", in_ready, 1'b1);
         end
         if (c == 33) chk("pp_empty", out_valid, 1'b0);
      end

      // Mid-operation reset with two blocks in flight, then a fresh block
      do_reset();
      for (int c = 0; c <= 47; c++) begin
         if (c > 0) next();
         nrst = (c != 15);
         in_valid = (c < 2) || (c == 16);
         in_tag = (c == 0) ? 4'd3 : (c == 1) ? 4'd4 : 4'd7;
         out_ready = 1'b1; #1;
         if (c == 15) begin
            chk("mr_dp_forced", dp_feedback, 1'b0);
            chk("mr_rcon_forced", dp_rcon, 8'h00);
            chk("mr_in_ready_forced", in_ready, 1'b0);
         end
         if (c == 16) begin
            chk("mr_inflight", inflight, 2'd0);
            chk("mr_out_valid", out_valid, 1'b0);
            chk("mr_slot", dp_slot, 2'd0);
            chk("mr_feedback", dp_feedback, 1'b0);
            chk("mr_fresh_fetch", dp_fetch, 1'b1);
         end
         if (c >= 17 && c <= 46) chk("mr_no_stale_output", out_valid, 1'b0);
         if (c == 46) chk("mr_capture", dp_clean, 1'b1);
         if (c == 47) begin
            chk("mr_fresh_valid", out_valid, 1'b1);
            chk("mr_fresh_tag", out_tag, 4'd7);
         end
      end
      in_valid = 1'b0;

      // Long schedule with three interleaved blocks (NR=14, OUT_DEPTH=3)
      do_reset();
      l_out_ready = 1'b1;
      for (int c = 0; c <= 46; c++) begin
         if (c > 0) next();
         l_in_valid = (c < 3); l_in_tag = 4'(c + 1); #1;
         if (c < 3) chk("il_accept", l_in_ready, 1'b1);
         if (c == 3) begin
            chk("il_inflight_peak", l_inflight, 2'd3);
            chk("il_full", l_in_ready, 1'b0);
         end
         if ((c % 3 == 0) && (c >= 3) && (c <= 39)) begin
            chk("ls_feedback", l_dp_feedback, 1'b1);
            chk("ls_rcon", l_dp_rcon, rc_tbl[c/3-1]);
            chk("ls_final", l_dp_final, c == 39);
         end
         if (c == 42) begin
            chk("ls_capture", l_dp_clean, 1'b1);
            chk("ls_capture_slot", l_dp_slot, 2'd0);
            chk("ls_not_yet", l_out_valid, 1'b0);
         end
         if (c >= 43 && c <= 45) begin
            chk("il_out_valid", l_out_valid, 1'b1);
            chk("il_out_tag", l_out_tag, 4'(c - 42));
         end
         if (c == 46) chk("il_drained", l_out_valid, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
